// File: rtl/fb_pkg.sv
// fb_pkg: shared types and constants for the framebuffer scanout path.
//   PIXEL_W        - RGB565 pixel width
//   BANK_ADDR_BITS - in-bank address width of the chained framebuffer BRAM
//   pixel_t        - one pixel word
//   state_e        - scanout controller states
package fb_pkg;
   localparam int PIXEL_W        = 16;
   localparam int BANK_ADDR_BITS = 8;
   typedef logic [PIXEL_W-1:0] pixel_t;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/fb_scanout_pix_fifo2.sv
// pix_fifo2: 2-entry first-word-fall-through pixel FIFO.
//   clk, rst_n  - clock, async active-low reset
//   flush       - synchronous empty
//   push, din   - write one pixel (caller guarantees no overflow)
//   pop         - consume head (caller guarantees non-empty)
//   dout        - head pixel, valid while count != 0
//   count       - occupancy 0..2
module pix_fifo2
   import fb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       push,
   input  logic       pop,
   input  pixel_t     din,
   output pixel_t     dout,
   output logic [1:0] count
);
   pixel_t     mem_q [2];
   pixel_t     mem_d [2];
   logic       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [1:0] count_q, count_d;

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = din;
      wr_ptr_d = flush ? 1'b0 : wr_ptr_q ^ push;
      rd_ptr_d = flush ? 1'b0 : rd_ptr_q ^ pop;
      count_d  = flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/fb_scanout_ctrl.sv
// fb_scanout_ctrl: streams a run of framebuffer pixels from the banked BRAM to the display driver.
//   clk, rst_n               - clock, async active-low reset
//   start, abort             - begin a run (IDLE only) / flush to IDLE
//   start_addr, length       - run descriptor, latched on start
//   busy, done               - run in progress / one-cycle completion pulse
//   mem_raddr, mem_ren       - BRAM read port
//   mem_rdata                - BRAM data, one cycle after the address
//   pix_data/valid/ready/last - pixel stream to the display driver
module fb_scanout_ctrl
   import fb_pkg::*;
#(
   parameter int ADDR_BITS = 9,
   parameter int LEN_BITS  = ADDR_BITS + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [ADDR_BITS-1:0] start_addr,
   input  logic [LEN_BITS-1:0]  length,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_BITS-1:0] mem_raddr,
   output logic                 mem_ren,
   input  pixel_t               mem_rdata,
   output pixel_t               pix_data,
   output logic                 pix_valid,
   input  logic                 pix_ready,
   output logic                 pix_last
);
   state_e               state_q, state_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d, raddr_q, raddr_d;
   logic [LEN_BITS-1:0]  issue_rem_q, issue_rem_d, out_rem_q, out_rem_d;
   logic                 inflight_q, inflight_d;
   logic [1:0]           fifo_count;
   logic                 pop, push, credit_ok, bank_ok, issue;

   assign pix_valid = fifo_count != 2'd0;
   assign pop       = pix_valid && pix_ready;
   assign pix_last  = pix_valid && out_rem_q == LEN_BITS'(1);
   assign push      = inflight_q && !abort;
   // Occupancy + in-flight - pop < 2, rearranged to avoid underflow.
   assign credit_ok = ({1'b0, fifo_count} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop});
   // The BRAM output mux follows the current bank select, so a capture cycle
   // may not move to another bank; after an in-bank address of FF we hold.
   assign bank_ok   = !inflight_q || raddr_q[BANK_ADDR_BITS-1:0] != '1;
   assign issue     = state_q == RUN && issue_rem_q != '0 && credit_ok && bank_ok && !abort;
   assign mem_ren   = issue || inflight_q;
   assign mem_raddr = issue ? addr_q : raddr_q;
   assign busy      = state_q == RUN || state_q == DRAIN;
   assign done      = state_q == DONE;

   always_comb begin
      state_d     = state_q;
      addr_d      = issue ? addr_q + ADDR_BITS'(1) : addr_q;
      issue_rem_d = issue ? issue_rem_q - LEN_BITS'(1) : issue_rem_q;
      out_rem_d   = pop ? out_rem_q - LEN_BITS'(1) : out_rem_q;
      raddr_d     = mem_raddr;
      inflight_d  = issue;
      case (state_q)
         IDLE: if (start) begin
            addr_d      = start_addr;
            issue_rem_d = length;
            out_rem_d   = length;
            state_d     = length != '0 ? RUN : DONE;
         end
         RUN:     state_d = issue && issue_rem_q == LEN_BITS'(1) ? DRAIN : RUN;
         DRAIN:   state_d = pop && pix_last ? DONE : DRAIN;
         default: state_d = IDLE;
      endcase
      if (abort) begin
         state_d     = IDLE;
         issue_rem_d = '0;
         out_rem_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         raddr_q     <= '0;
         issue_rem_q <= '0;
         out_rem_q   <= '0;
         inflight_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         raddr_q     <= raddr_d;
         issue_rem_q <= issue_rem_d;
         out_rem_q   <= out_rem_d;
         inflight_q  <= inflight_d;
      end
   end

   pix_fifo2 u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (abort),
      .push  (push),
      .pop   (pop),
      .din   (mem_rdata),
      .dout  (pix_data),
      .count (fifo_count)
   );
endmodule
